// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 slave backed by a word-addressed internal SRAM.
// Reads and writes run on independent FSMs, with one outstanding transaction each.
// Single and burst (FIXED/INCR; WRAP handled as INCR) transfers on a 32-bit bus.
// Ports: clk, rst_n (async, active-low); AW/W/B write channels; AR/R read channels.
// Word index = ((addr - BASE_ADDR) >> 2) mod MEM_WORDS; addr[1:0] is ignored.
// Optional: define AXI4_MEM_SLAVE_RANGE_CHECK_EN to give DECERR on beats outside
// [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS). Otherwise such addresses alias via the modulo index.
module axi4_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned ID_W      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            aw_valid,
    output logic            aw_ready,
    input  logic [31:0]     aw_addr,
    input  logic [ID_W-1:0] aw_id,
    input  logic [7:0]      aw_len,
    input  logic [2:0]      aw_size,
    input  logic [1:0]      aw_burst,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [31:0]     w_data,
    input  logic [3:0]      w_strb,
    input  logic            w_last,
    output logic            b_valid,
    input  logic            b_ready,
    output logic [1:0]      b_resp,
    output logic [ID_W-1:0] b_id,
    input  logic            ar_valid,
    output logic            ar_ready,
    input  logic [31:0]     ar_addr,
    input  logic [ID_W-1:0] ar_id,
    input  logic [7:0]      ar_len,
    input  logic [2:0]      ar_size,
    input  logic [1:0]      ar_burst,
    output logic            r_valid,
    input  logic            r_ready,
    output logic [31:0]     r_data,
    output logic [1:0]      r_resp,
    output logic            r_last,
    output logic [ID_W-1:0] r_id
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem_q [MEM_WORDS];

    // Write-side state
    logic [1:0]      w_state_q, w_state_d;
    logic            aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic [1:0]      b_resp_q, b_resp_d;
    logic [ID_W-1:0] b_id_q, b_id_d;
    logic [31:0]     w_addr_q, w_addr_d;
    logic [7:0]      w_cnt_q, w_cnt_d;
    logic            w_fixed_q, w_fixed_d, w_err_q, w_err_d, w_dec_q, w_dec_d;
    logic            w_hs_c, w_oor_c, w_last_err_c, w_err_n_c, w_dec_n_c;

    // Read-side state
    logic            r_state_q, r_state_d;
    logic            ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [31:0]     r_data_q, r_data_d, r_addr_q, r_addr_d;
    logic [1:0]      r_resp_q, r_resp_d;
    logic [ID_W-1:0] r_id_q, r_id_d;
    logic [7:0]      r_cnt_q, r_cnt_d;
    logic            r_fixed_q, r_fixed_d, r_serr_q, r_serr_d;
    logic            ld_c, ld_last_c, ld_serr_c, ld_oor_c, r_done_c;
    logic [31:0]     ld_addr_c;

`ifdef AXI4_MEM_SLAVE_RANGE_CHECK_EN
    localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);
    assign w_oor_c  = (w_addr_q - BASE_ADDR) >= SPAN;
    assign ld_oor_c = (ld_addr_c - BASE_ADDR) >= SPAN;
`else
    assign w_oor_c  = 1'b0;
    assign ld_oor_c = 1'b0;
`endif

    assign w_hs_c       = w_valid && w_ready_q;
    // w_last must coincide exactly with the final counted beat
    assign w_last_err_c = w_last != (w_cnt_q == 8'd0);
    assign w_err_n_c    = w_err_q | w_last_err_c;
    assign w_dec_n_c    = w_dec_q | w_oor_c;

    // Write FSM next state
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        b_id_d     = b_id_q;
        w_addr_d   = w_addr_q;
        w_cnt_d    = w_cnt_q;
        w_fixed_d  = w_fixed_q;
        w_err_d    = w_err_q;
        w_dec_d    = w_dec_q;
        case (w_state_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_valid && aw_ready_q) begin
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_addr_d   = aw_addr;
                    w_cnt_d    = aw_len;
                    w_fixed_d  = aw_burst == BURST_FIXED;
                    // unsupported beat size folds into the burst error flag
                    w_err_d    = aw_size != SIZE_WORD;
                    w_dec_d    = 1'b0;
                    b_id_d     = aw_id;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs_c) begin
                    w_err_d  = w_err_n_c;
                    w_dec_d  = w_dec_n_c;
                    w_cnt_d  = w_cnt_q - 8'd1;
                    w_addr_d = w_fixed_q ? w_addr_q : w_addr_q + 32'd4;
                    if (w_cnt_q == 8'd0) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_resp_d  = w_dec_n_c ? RESP_DECERR :
                                    (w_err_n_c ? RESP_SLVERR : RESP_OKAY);
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_ready && b_valid_q) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            b_id_q     <= '0;
            w_addr_q   <= '0;
            w_cnt_q    <= '0;
            w_fixed_q  <= 1'b0;
            w_err_q    <= 1'b0;
            w_dec_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            b_id_q     <= b_id_d;
            w_addr_q   <= w_addr_d;
            w_cnt_q    <= w_cnt_d;
            w_fixed_q  <= w_fixed_d;
            w_err_q    <= w_err_d;
            w_dec_q    <= w_dec_d;
        end
    end

    // Byte-strobed SRAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_hs_c && !w_oor_c) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) mem_q[word_idx(w_addr_q)][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // Read FSM next state; ld_c requests a beat fetch into the output register
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_id_d     = r_id_q;
        r_addr_d   = r_addr_q;
        r_cnt_d    = r_cnt_q;
        r_fixed_d  = r_fixed_q;
        r_serr_d   = r_serr_q;
        ld_c       = 1'b0;
        ld_addr_c  = r_addr_q;
        ld_last_c  = 1'b0;
        ld_serr_c  = r_serr_q;
        r_done_c   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_valid && ar_ready_q) begin
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_id_d     = ar_id;
                    r_addr_d   = ar_addr;
                    r_cnt_d    = ar_len;
                    r_fixed_d  = ar_burst == BURST_FIXED;
                    r_serr_d   = ar_size != SIZE_WORD;
                    ld_c       = 1'b1;
                    ld_addr_c  = ar_addr;
                    ld_last_c  = ar_len == 8'd0;
                    ld_serr_c  = ar_size != SIZE_WORD;
                    r_state_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (r_valid_q && r_ready) begin
                    if (r_cnt_q == 8'd0) begin
                        r_valid_d  = 1'b0;
                        ar_ready_d = 1'b1;
                        r_done_c   = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        r_addr_d  = r_fixed_q ? r_addr_q : r_addr_q + 32'd4;
                        r_cnt_d   = r_cnt_q - 8'd1;
                        ld_c      = 1'b1;
                        ld_addr_c = r_addr_d;
                        ld_last_c = r_cnt_q == 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Beat payload; a fetch in the same cycle as a write to that word sees the old value
    always_comb begin
        r_data_d = r_data_q;
        r_resp_d = r_resp_q;
        r_last_d = r_last_q;
        if (ld_c) begin
            if (ld_oor_c) begin
                r_data_d = '0;
                r_resp_d = RESP_DECERR;
            end else begin
                r_data_d = mem_q[word_idx(ld_addr_c)];
                r_resp_d = ld_serr_c ? RESP_SLVERR : RESP_OKAY;
            end
            r_last_d = ld_last_c;
        end else if (r_done_c) begin
            r_last_d = 1'b0;
        end
    end

    // Read FSM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_cnt_q    <= '0;
            r_fixed_q  <= 1'b0;
            r_serr_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_addr_q   <= r_addr_d;
            r_cnt_q    <= r_cnt_d;
            r_fixed_q  <= r_fixed_d;
            r_serr_q   <= r_serr_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_resp   = b_resp_q;
    assign b_id     = b_id_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;
    assign r_id     = r_id_q;
endmodule
